// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end.
//   XLEN          : instruction / address width (32)
//   RESET_PC_DEF  : default PC loaded on reset
//   INST_BUBBLE   : instruction word carried by a bubble
//   ifid_t        : IF/ID pipeline register layout
//   IFID_BUBBLE   : IF/ID value for an empty slot (also the reset value)
//   pc_sel_e      : next-PC source select for pc_reg
//   align_word()  : clears the two low address bits of a fetch target
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_BUBBLE  = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
        logic            valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        pc:    32'h0000_0000,
        pc4:   32'h0000_0000,
        inst:  INST_BUBBLE,
        valid: 1'b0
    };

    typedef enum logic [1:0] {
        PC_SEL_REDIRECT = 2'd0,
        PC_SEL_HOLD     = 2'd1,
        PC_SEL_INC      = 2'd2
    } pc_sel_e;

    // Fetch targets are word aligned; the low two bits are discarded.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register with its priority next-PC mux:
//   reset > redirect > hold > PC+4 (wraps modulo 2^32).
// Ports:
//   clk_i         in   clock, rising edge
//   rst_i         in   synchronous active-high reset, loads RESET_PC
//   hold_i        in   keep the current PC
//   redirect_i    in   load the aligned redirect target
//   redirect_pc_i in   redirect target address
//   pc_o          out  current PC (register output)
// -----------------------------------------------------------------------------
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            hold_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o
);

    pc_sel_e         sel_s;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    // Next-PC source selection; redirect outranks hold.
    always_comb begin
        sel_s = PC_SEL_INC;
        if (redirect_i) begin
            sel_s = PC_SEL_REDIRECT;
        end else if (hold_i) begin
            sel_s = PC_SEL_HOLD;
        end else begin
            sel_s = PC_SEL_INC;
        end
    end

    // Next-PC value for the selected source.
    always_comb begin
        pc_d = pc_q;
        case (sel_s)
            PC_SEL_REDIRECT: pc_d = align_word(redirect_pc_i);
            PC_SEL_HOLD:     pc_d = pc_q;
            PC_SEL_INC:      pc_d = pc_q + 32'd4;
            default:         pc_d = pc_q;
        endcase
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction fetch stage: PC register, instruction ROM addressing and the
// IF/ID pipeline register, with a one-cycle warm-up after reset.
// Ports:
//   clk_i          in   clock, rising edge
//   rst_i          in   synchronous active-high reset
//   stall_i        in   load-use hold from the hazard unit
//   redirect_i     in   taken branch / jump resolved downstream
//   redirect_pc_i  in   redirect target
//   irom_addr_o    out  instruction ROM address (current PC)
//   irom_inst_i    in   ROM data for irom_addr_o, same cycle
//   pc_o           out  IF/ID: PC of the held instruction
//   pc4_o          out  IF/ID: pc_o + 4
//   inst_o         out  IF/ID: instruction word
//   valid_o        out  IF/ID: 1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] irom_addr_o,
    input  logic [XLEN-1:0] irom_inst_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic [XLEN-1:0] inst_o,
    output logic            valid_o
);

    logic            warm_q;
    ifid_t           ifid_d;
    ifid_t           ifid_q;
    logic [XLEN-1:0] pc_s;
    logic            pc_redirect_s;
    logic            pc_hold_s;

    // During warm-up the PC sits at RESET_PC and redirects are ignored.
    assign pc_redirect_s = redirect_i & warm_q;
    assign pc_hold_s     = stall_i | ~warm_q;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .hold_i        (pc_hold_s),
        .redirect_i    (pc_redirect_s),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_s)
    );

    // IF/ID next value: bubble during warm-up or on redirect, hold on stall,
    // otherwise capture the current fetch.
    always_comb begin
        ifid_d = ifid_q;
        if (!warm_q || redirect_i) begin
            ifid_d = IFID_BUBBLE;
        end else if (stall_i) begin
            ifid_d = ifid_q;
        end else begin
            ifid_d = '{pc: pc_s, pc4: pc_s + 32'd4, inst: irom_inst_i, valid: 1'b1};
        end
    end

    // Warm-up flag and IF/ID register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            warm_q <= 1'b0;
            ifid_q <= IFID_BUBBLE;
        end else begin
            warm_q <= 1'b1;
            ifid_q <= ifid_d;
        end
    end

    assign irom_addr_o = pc_s;
    assign pc_o        = ifid_q.pc;
    assign pc4_o       = ifid_q.pc4;
    assign inst_o      = ifid_q.inst;
    assign valid_o     = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] irom_addr_o;
    logic [31:0] irom_inst_i;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic [31:0] inst_o;
    logic        valid_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        exp_v;
    exp_t        m_ifid;
    logic [31:0] m_pc;
    logic        m_warm;
    int          checks;
    int          errors;

    if_stage #(
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .irom_addr_o   (irom_addr_o),
        .irom_inst_i   (irom_inst_i),
        .pc_o          (pc_o),
        .pc4_o         (pc4_o),
        .inst_o        (inst_o),
        .valid_o       (valid_o)
    );

    // ROM contents: distinct word per address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0013_5700;
    endfunction

    assign irom_inst_i = rom(irom_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, advance the reference model, push the
    // expected IF/ID value, then wait for the edge and settle.
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        rst_i         = r;
        stall_i       = s;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        if (r) begin
            m_pc   = RESET_PC;
            m_warm = 1'b0;
            m_ifid = '0;
        end else if (!m_warm) begin
            m_warm = 1'b1;
            m_ifid = '0;
        end else if (rd) begin
            m_pc   = {rpc[31:2], 2'b00};
            m_ifid = '0;
        end else if (s) begin
            m_ifid = m_ifid;
        end else begin
            m_ifid = '{pc: m_pc, pc4: m_pc + 32'd4, inst: rom(m_pc), valid: 1'b1};
            m_pc   = m_pc + 32'd4;
        end
        sb_q.push_back(m_ifid);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0000_0000);
            exp_v = sb_q.pop_front();
            checks++;
            if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v) begin
                errors++;
                $display("FAIL reset_ifid got %h required %h", {pc_o, pc4_o, inst_o, valid_o}, exp_v);
            end
            checks++;
            if (irom_addr_o !== RESET_PC || valid_o !== 1'b0 || pc_o !== 32'h0) begin
                errors++;
                $display("FAIL reset_state got addr=%h valid=%b pc=%h required addr=%h valid=0 pc=0",
                         irom_addr_o, valid_o, pc_o, RESET_PC);
            end
        end
    endtask

    task automatic test_warmup_fetch();
        // warm-up edge: bubble, PC held
        step(1'b0, 1'b0, 1'b0, 32'h0000_0000);
        exp_v = sb_q.pop_front();
        checks++;
        if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL warmup_bubble got %h required %h", {pc_o, pc4_o, inst_o, valid_o}, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (irom_addr_o !== 32'(i * 4)) begin
                errors++;
                $display("FAIL fetch_addr got %h required %h", irom_addr_o, 32'(i * 4));
            end
            step(1'b0, 1'b0, 1'b0, 32'h0000_0000);
            exp_v = sb_q.pop_front();
            checks++;
            if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v) begin
                errors++;
                $display("FAIL fetch_ifid got %h required %h", {pc_o, pc4_o, inst_o, valid_o}, exp_v);
            end
            checks++;
            if (inst_o !== rom(32'(i * 4)) || valid_o !== 1'b1 || pc4_o !== 32'(i * 4 + 4)) begin
                errors++;
                $display("FAIL fetch_latency got inst=%h valid=%b pc4=%h required inst=%h valid=1 pc4=%h",
                         inst_o, valid_o, pc4_o, rom(32'(i * 4)), 32'(i * 4 + 4));
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8 && pc_o !== 32'h10; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0000_0000);
            exp_v = sb_q.pop_front();
            checks++;
            if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v) begin
                errors++;
                $display("FAIL stall_prep got %h required %h", {pc_o, pc4_o, inst_o, valid_o}, exp_v);
            end
        end
        checks++;
        if (pc_o !== 32'h10) begin
            errors++;
            $display("FAIL stall_reach got pc=%h required 00000010", pc_o);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0000_0000);
            exp_v = sb_q.pop_front();
            checks++;
            if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v) begin
                errors++;
                $display("FAIL stall_ifid got %h required %h", {pc_o, pc4_o, inst_o, valid_o}, exp_v);
            end
            checks++;
            if (pc_o !== 32'h10 || inst_o !== rom(32'h10) || irom_addr_o !== 32'h14) begin
                errors++;
                $display("FAIL stall_freeze got pc=%h inst=%h addr=%h required pc=10 inst=%h addr=14",
                         pc_o, inst_o, irom_addr_o, rom(32'h10));
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0000_0000);
            exp_v = sb_q.pop_front();
            checks++;
            if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v) begin
                errors++;
                $display("FAIL stall_resume_ifid got %h required %h", {pc_o, pc4_o, inst_o, valid_o}, exp_v);
            end
            checks++;
            if (pc_o !== 32'(32'h14 + i * 4) || inst_o !== rom(32'(32'h14 + i * 4)) || valid_o !== 1'b1) begin
                errors++;
                $display("FAIL stall_resume got pc=%h inst=%h required pc=%h inst=%h",
                         pc_o, inst_o, 32'(32'h14 + i * 4), rom(32'(32'h14 + i * 4)));
            end
        end
    endtask

    task automatic test_redirect_stalled();
        step(1'b0, 1'b1, 1'b1, 32'h0000_0203);
        exp_v = sb_q.pop_front();
        checks++;
        if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v) begin
            errors++;
            $display("FAIL redir_stall_ifid got %h required %h", {pc_o, pc4_o, inst_o, valid_o}, exp_v);
        end
        checks++;
        if (irom_addr_o !== 32'h200 || valid_o !== 1'b0 || inst_o !== 32'h0) begin
            errors++;
            $display("FAIL redir_stall_pc got addr=%h valid=%b inst=%h required addr=200 valid=0 inst=0",
                     irom_addr_o, valid_o, inst_o);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0000_0000);
        exp_v = sb_q.pop_front();
        checks++;
        if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v) begin
            errors++;
            $display("FAIL redir_target_ifid got %h required %h", {pc_o, pc4_o, inst_o, valid_o}, exp_v);
        end
        checks++;
        if (pc_o !== 32'h200 || inst_o !== rom(32'h200) || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL redir_target got pc=%h inst=%h valid=%b required pc=200 inst=%h valid=1",
                     pc_o, inst_o, valid_o, rom(32'h200));
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        exp_v = sb_q.pop_front();
        checks++;
        if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v || irom_addr_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_setup got ifid=%h addr=%h required ifid=%h addr=fffffffc",
                     {pc_o, pc4_o, inst_o, valid_o}, irom_addr_o, exp_v);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0000_0000);
            exp_v = sb_q.pop_front();
            checks++;
            if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v) begin
                errors++;
                $display("FAIL wrap_ifid got %h required %h", {pc_o, pc4_o, inst_o, valid_o}, exp_v);
            end
        end
        // second instruction after the wrap sits at address 0
        checks++;
        if (pc_o !== 32'h0 || pc4_o !== 32'h4 || irom_addr_o !== 32'h4) begin
            errors++;
            $display("FAIL wrap_zero got pc=%h pc4=%h addr=%h required pc=0 pc4=4 addr=4",
                     pc_o, pc4_o, irom_addr_o);
        end
    endtask

    task automatic test_wrap_edge();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        exp_v = sb_q.pop_front();
        step(1'b0, 1'b0, 1'b0, 32'h0000_0000);
        exp_v = sb_q.pop_front();
        checks++;
        if (pc_o !== 32'hFFFF_FFFC || pc4_o !== 32'h0 || irom_addr_o !== 32'h0 || {pc_o, pc4_o, inst_o, valid_o} !== exp_v) begin
            errors++;
            $display("FAIL wrap_pc4 got pc=%h pc4=%h addr=%h required pc=fffffffc pc4=0 addr=0",
                     pc_o, pc4_o, irom_addr_o);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        exp_v = sb_q.pop_front();
        checks++;
        if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v || irom_addr_o !== RESET_PC || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got ifid=%h addr=%h required ifid=%h addr=%h",
                     {pc_o, pc4_o, inst_o, valid_o}, irom_addr_o, exp_v, RESET_PC);
        end
        // redirect during the warm-up edge must be ignored
        step(1'b0, 1'b0, 1'b1, 32'h0000_0300);
        exp_v = sb_q.pop_front();
        checks++;
        if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v || irom_addr_o !== RESET_PC) begin
            errors++;
            $display("FAIL warmup_redirect got ifid=%h addr=%h required ifid=%h addr=%h",
                     {pc_o, pc4_o, inst_o, valid_o}, irom_addr_o, exp_v, RESET_PC);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0000_0000);
        exp_v = sb_q.pop_front();
        checks++;
        if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v || pc_o !== RESET_PC || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_resume got pc=%h valid=%b required pc=%h valid=1", pc_o, valid_o, RESET_PC);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt [2];
        tgt[0] = 32'h40;
        tgt[1] = 32'h80;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, tgt[i]);
            exp_v = sb_q.pop_front();
            checks++;
            if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v || valid_o !== 1'b0 || irom_addr_o !== tgt[i]) begin
                errors++;
                $display("FAIL b2b_bubble got ifid=%h addr=%h required ifid=%h addr=%h",
                         {pc_o, pc4_o, inst_o, valid_o}, irom_addr_o, exp_v, tgt[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0000_0000);
            exp_v = sb_q.pop_front();
            checks++;
            if ({pc_o, pc4_o, inst_o, valid_o} !== exp_v) begin
                errors++;
                $display("FAIL b2b_ifid got %h required %h", {pc_o, pc4_o, inst_o, valid_o}, exp_v);
            end
            checks++;
            if (pc_o !== 32'(32'h80 + i * 4) || valid_o !== 1'b1 || (valid_o === 1'b1 && pc_o === 32'h40)) begin
                errors++;
                $display("FAIL b2b_target got pc=%h valid=%b required pc=%h valid=1",
                         pc_o, valid_o, 32'(32'h80 + i * 4));
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        m_pc          = RESET_PC;
        m_warm        = 1'b0;
        m_ifid        = '0;
        rst_i         = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        test_reset();
        test_warmup_fetch();
        test_stall();
        test_redirect_stalled();
        test_wrap();
        test_wrap_edge();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
